bka16_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit Brent-Kung adder among `NREQ` requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester and registers its operands, drives the shared adder, and returns the registered sum tagged with the requester index through a valid/ready response port. It sits between client address/accumulate units and the single adder instance, so that instance does not have to be replicated.

---
 rtl/bka_arb_pkg.sv | 15 +
 rtl/bka16_share_arb_adder.sv | 38 +++
 rtl/bka16_share_arb_rr_pick.sv | 26 ++
 rtl/bka16_share_arb.sv | 125 ++++++++++++
 tb/tb_bka16_share_arb.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bka_arb_pkg.sv
// Shared definitions for bka16_share_arb: FSM states, operand width, NREQ bounds check.
// Optional flag outputs are enabled with the BKA_ARB_FLAGS_EN macro.
package bka_arb_pkg;
   localparam int OPW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } arb_state_t;

   function automatic bit nreq_in_range(input int n);
      return (n >= 2) && (n <= 8);
   endfunction
endpackage

// File: rtl/bka16_share_arb_adder.sv
// 16-bit Brent-Kung prefix adder, no carry-in and no carry-out.
module bka16_adder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] s
);
   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [15:0] w_p0;

   always_comb begin
      w_p0 = a ^ b;
      w_g  = a & b;
      w_p  = a ^ b;
      // Up-sweep: group generate/propagate at spans 2,4,8,16.
      for (int l = 1; l <= 4; l++) begin
         for (int i = 0; i < 16; i++) begin
            if (((i + 1) % (1 << l)) == 0) begin
               w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << (l - 1))]);
               w_p[i] = w_p[i] & w_p[i - (1 << (l - 1))];
            end
         end
      end
      // Down-sweep fills in the remaining prefixes at distances 4,2,1.
      for (int d = 4; d >= 1; d = d / 2) begin
         for (int i = 0; i < 16; i++) begin
            if ((((i + 1) % (2 * d)) == d) && ((i + 1) > (2 * d))) begin
               w_g[i] = w_g[i] | (w_p[i] & w_g[i - d]);
               w_p[i] = w_p[i] & w_p[i - d];
            end
         end
      end
      s    = w_p0;
      for (int i = 1; i < 16; i++) begin
         s[i] = w_p0[i] ^ w_g[i - 1];
      end
   end
endmodule

// File: rtl/bka16_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any_valid
);
   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      // Scan farthest-first so the closest valid requester is written last and wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) begin
            grant = '0;
            grant[(int'(ptr) + k) % NREQ] = 1'b1;
            idx = IDW'((int'(ptr) + k) % NREQ);
            any_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bka16_share_arb.sv
// Round-robin sharing of one 16-bit Brent-Kung adder among NREQ requesters.
// Define BKA_ARB_FLAGS_EN to add registered rsp_cout / rsp_ovf outputs.
module bka16_share_arb
   import bka_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*OPW-1:0] req_a,
   input  logic [NREQ*OPW-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [OPW-1:0]      rsp_q,
   output logic [IDW-1:0]      rsp_id,
`ifdef BKA_ARB_FLAGS_EN
   output logic                rsp_cout,
   output logic                rsp_ovf,
`endif
   output logic                busy
);
   if (!nreq_in_range(NREQ)) begin : g_nreq_check
      $error("bka16_share_arb: NREQ must be in 2..8");
   end

   arb_state_t     r_state, w_state_next;
   logic [IDW-1:0] r_ptr, r_gid, r_rsp_id, w_idx, w_ptr_next;
   logic [OPW-1:0] r_a, r_b, r_rsp_q, w_sum;
   logic [NREQ-1:0] w_grant;
   logic           w_any, w_arb_en, w_take, r_rsp_valid;
   logic [OPW-1:0] w_a_arr [NREQ];
   logic [OPW-1:0] w_b_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[gi*OPW +: OPW];
      assign w_b_arr[gi] = req_b[gi*OPW +: OPW];
   end

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req_valid (req_valid),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .idx       (w_idx),
      .any_valid (w_any)
   );

   bka16_adder u_adder (
      .a (r_a),
      .b (r_b),
      .s (w_sum)
   );

   assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

   always_comb begin
      w_state_next = r_state;
      w_arb_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_arb_en = 1'b1;
            if (w_any) w_state_next = ST_EXEC;
         end
         ST_EXEC: w_state_next = ST_HOLD;
         ST_HOLD: begin
            if (rsp_ready) begin
               w_arb_en     = 1'b1;
               w_state_next = w_any ? ST_EXEC : ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      w_take    = w_arb_en & w_any & ~rst;
      req_ready = w_take ? w_grant : '0;
   end

`ifdef BKA_ARB_FLAGS_EN
   logic r_rsp_cout, r_rsp_ovf;
   assign rsp_cout = r_rsp_cout;
   assign rsp_ovf  = r_rsp_ovf;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_gid       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_q     <= '0;
         r_rsp_id    <= '0;
`ifdef BKA_ARB_FLAGS_EN
         r_rsp_cout  <= 1'b0;
         r_rsp_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         if (w_take) begin
            r_a   <= w_a_arr[w_idx];
            r_b   <= w_b_arr[w_idx];
            r_gid <= w_idx;
            r_ptr <= w_ptr_next;
         end
         if (r_state == ST_EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_q     <= w_sum;
            r_rsp_id    <= r_gid;
`ifdef BKA_ARB_FLAGS_EN
            r_rsp_cout  <= (r_a[15] & r_b[15]) | ((r_a[15] ^ r_b[15]) & ~w_sum[15]);
            r_rsp_ovf   <= (r_a[15] == r_b[15]) & (w_sum[15] != r_a[15]);
`endif
         end else if ((r_state == ST_HOLD) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_q     = r_rsp_q;
   assign rsp_id    = r_rsp_id;
   assign busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_bka16_share_arb.sv
// Directed self-checking bench for bka16_share_arb (NREQ=4); flag checks follow BKA_ARB_FLAGS_EN.
module tb_bka16_share_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a, req_b;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_q;
   logic [1:0]  rsp_id;
   logic        busy;
`ifdef BKA_ARB_FLAGS_EN
   logic        rsp_cout, rsp_ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   bka16_share_arb #(.NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_q     (rsp_q),
      .rsp_id    (rsp_id),
`ifdef BKA_ARB_FLAGS_EN
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
   endtask

   task automatic show_rsp();
      $display("[TB] rsp id=%0d q=%04h", rsp_id, rsp_q);
   endtask

   logic [15:0] exp_sum [4];
   int          gord [6];
   logic [3:0]  oh;

   initial begin
      exp_sum = '{16'h1211, 16'h2323, 16'h3435, 16'h4547};
      gord    = '{3, 0, 1, 2, 3, 0};
      rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      tick(); tick();
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_q",     32'(rsp_q),     32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
`ifdef BKA_ARB_FLAGS_EN
      chk("rst_flags", 32'({rsp_cout, rsp_ovf}), 32'h0);
`endif
      tick();
      rst = 1'b0; req_valid = 4'h0;
      tick();

      // Single request from requester 0
      set_op(0, 16'h1234, 16'h0001); req_valid = 4'b0001;
      #1;
      chk("single_grant", 32'(req_ready), 32'h1);
      chk("single_idle_busy", 32'(busy), 32'h0);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("single_exec_busy", 32'(busy), 32'h1);
      chk("single_exec_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("single_valid", 32'(rsp_valid), 32'h1);
      chk("single_q",     32'(rsp_q),     32'h1235);
      chk("single_id",    32'(rsp_id),    32'h0);
      show_rsp();
      tick();
      chk("single_done_valid", 32'(rsp_valid), 32'h0);
      chk("single_done_busy",  32'(busy),      32'h0);

      // Wrap-around sum from requester 1
      set_op(1, 16'hFFFF, 16'h0001); req_valid = 4'b0010;
      #1;
      chk("wrap_grant", 32'(req_ready), 32'h2);
      tick(); req_valid = 4'b0000;
      tick();
      chk("wrap_q",  32'(rsp_q),  32'h0000);
      chk("wrap_id", 32'(rsp_id), 32'h1);
`ifdef BKA_ARB_FLAGS_EN
      chk("wrap_cout", 32'(rsp_cout), 32'h1);
      chk("wrap_ovf",  32'(rsp_ovf),  32'h0);
`endif
      show_rsp();
      tick();

      // Signed overflow from requester 2
      set_op(2, 16'h7FFF, 16'h0001); req_valid = 4'b0100;
      #1;
      chk("ovf_grant", 32'(req_ready), 32'h4);
      tick(); req_valid = 4'b0000;
      tick();
      chk("ovf_q",  32'(rsp_q),  32'h8000);
      chk("ovf_id", 32'(rsp_id), 32'h2);
`ifdef BKA_ARB_FLAGS_EN
      chk("ovf_cout", 32'(rsp_cout), 32'h0);
      chk("ovf_ovf",  32'(rsp_ovf),  32'h1);
`endif
      show_rsp();
      tick();

      // Fairness: all valid, pointer now at 3
      for (int i = 0; i < 4; i++) set_op(i, 16'h1111 * 16'(i + 1), 16'h0100 + 16'(i));
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 6; k++) begin
         oh = 4'b0001 << gord[k];
         chk($sformatf("fair_grant%0d", k), 32'(req_ready), 32'(oh));
         tick();
         chk($sformatf("fair_exec_valid%0d", k), 32'(rsp_valid), 32'h0);
         chk($sformatf("fair_exec_ready%0d", k), 32'(req_ready), 32'h0);
         tick();
         chk($sformatf("fair_valid%0d", k), 32'(rsp_valid), 32'h1);
         chk($sformatf("fair_id%0d", k), 32'(rsp_id), 32'(gord[k]));
         chk($sformatf("fair_q%0d", k), 32'(rsp_q), 32'(exp_sum[gord[k]]));
         show_rsp();
      end

      // Backpressure: 5 cycles of rsp_ready low in HOLD
      rsp_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk($sformatf("bp_ready%0d", j), 32'(req_ready), 32'h0);
         chk($sformatf("bp_valid%0d", j), 32'(rsp_valid), 32'h1);
         chk($sformatf("bp_q%0d", j),     32'(rsp_q),     32'h1211);
         chk($sformatf("bp_id%0d", j),    32'(rsp_id),    32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_grant", 32'(req_ready), 32'h2);
      tick();

      // Reset during EXEC
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("midrst_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_q",     32'(rsp_q),     32'h0);
      chk("midrst_id",    32'(rsp_id),    32'h0);
      chk("midrst_busy",  32'(busy),      32'h0);
      rst = 1'b0;
      #1;
      chk("postrst_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'h0;
      #1;
      chk("postrst_exec_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("postrst_q",  32'(rsp_q),  32'h1211);
      chk("postrst_id", 32'(rsp_id), 32'h0);
      show_rsp();
      tick();
      chk("postrst_idle", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
